// File: rtl/ysyx_22050518_wb_stage.sv
// rtl/ysyx_22050518_wb_stage.sv - writeback merge of pipeline and long-latency results with pending scoreboard
// Optional commit trace (p_pc / commit_valid / commit_pc) enabled by YSYX_22050518_WB_COMMIT_PC_EN.
module ysyx_22050518_wb_stage #(
    parameter int XLEN = 64,
    parameter int NREG = 32,
    localparam int AW  = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            p_valid,
    output logic            p_ready,
    input  logic            p_wen,
    input  logic [AW-1:0]   p_rd_addr,
    input  logic [XLEN-1:0] p_data,
`ifdef YSYX_22050518_WB_COMMIT_PC_EN
    input  logic [XLEN-1:0] p_pc,
    output logic            commit_valid,
    output logic [XLEN-1:0] commit_pc,
`endif
    input  logic            l_valid,
    input  logic [AW-1:0]   l_rd_addr,
    input  logic [XLEN-1:0] l_data,
    input  logic            iss_valid,
    input  logic [AW-1:0]   iss_rd_addr,
    input  logic [AW-1:0]   rs1_addr,
    input  logic [AW-1:0]   rs2_addr,
    output logic            rs1_busy,
    output logic            rs2_busy,
    output logic            write_en,
    output logic [AW-1:0]   rd_addr,
    output logic [XLEN-1:0] rd,
    output logic [63:0]     instret
);

    logic            p_acc;
    logic [NREG-1:0] pending;
    logic [NREG-1:0] set_vec;
    logic [NREG-1:0] clr_vec;

    // Long-latency results cannot be back-pressured, so they always win the port.
    assign p_ready = !l_valid;
    assign p_acc   = p_valid & p_ready;

    always_comb begin
        set_vec = '0;
        clr_vec = '0;
        if (iss_valid && (iss_rd_addr != '0)) set_vec[iss_rd_addr] = 1'b1;
        if (l_valid) clr_vec[l_rd_addr] = 1'b1;
    end

    assign rs1_busy = pending[rs1_addr] & (rs1_addr != '0);
    assign rs2_busy = pending[rs2_addr] & (rs2_addr != '0);

    // Clear before set so a re-issue in the completing cycle keeps the bit pending.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending <= '0;
        end else begin
            pending <= (pending & ~clr_vec) | set_vec;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            write_en <= 1'b0;
            rd_addr  <= '0;
            rd       <= '0;
        end else if (l_valid) begin
            write_en <= (l_rd_addr != '0);
            rd_addr  <= l_rd_addr;
            rd       <= l_data;
        end else if (p_acc) begin
            write_en <= p_wen & (p_rd_addr != '0);
            rd_addr  <= p_rd_addr;
            rd       <= p_data;
        end else begin
            write_en <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instret <= '0;
        end else if (p_acc) begin
            instret <= instret + 64'd1;
        end
    end

`ifdef YSYX_22050518_WB_COMMIT_PC_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            commit_valid <= 1'b0;
            commit_pc    <= '0;
        end else begin
            commit_valid <= p_acc;
            if (p_acc) commit_pc <= p_pc;
        end
    end
`endif

endmodule

// File: tb/tb_ysyx_22050518_wb_stage.sv
// tb/tb_ysyx_22050518_wb_stage.sv - randomized self-checking bench for ysyx_22050518_wb_stage
module tb_ysyx_22050518_wb_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        p_valid = 1'b0;
    logic        p_ready;
    logic        p_wen = 1'b0;
    logic [4:0]  p_rd_addr = '0;
    logic [63:0] p_data = '0;
    logic        l_valid = 1'b0;
    logic [4:0]  l_rd_addr = '0;
    logic [63:0] l_data = '0;
    logic        iss_valid = 1'b0;
    logic [4:0]  iss_rd_addr = '0;
    logic [4:0]  rs1_addr = '0;
    logic [4:0]  rs2_addr = '0;
    logic        rs1_busy;
    logic        rs2_busy;
    logic        write_en;
    logic [4:0]  rd_addr;
    logic [63:0] rd;
    logic [63:0] instret;

    int n_total = 0;
    int n_pass  = 0;

    // Reference state: what the register file should see and which registers await a long result.
    logic        m_wen;
    logic [4:0]  m_addr;
    logic [63:0] m_rd;
    logic [63:0] m_inst;
    bit          m_pend [32];

    ysyx_22050518_wb_stage dut (
        .clk(clk), .rst_n(rst_n),
        .p_valid(p_valid), .p_ready(p_ready), .p_wen(p_wen),
        .p_rd_addr(p_rd_addr), .p_data(p_data),
        .l_valid(l_valid), .l_rd_addr(l_rd_addr), .l_data(l_data),
        .iss_valid(iss_valid), .iss_rd_addr(iss_rd_addr),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
        .write_en(write_en), .rd_addr(rd_addr), .rd(rd), .instret(instret)
    );

    initial forever #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    task automatic model_reset();
        m_wen = 1'b0; m_addr = '0; m_rd = '0; m_inst = '0;
        for (int i = 0; i < 32; i++) m_pend[i] = 1'b0;
    endtask

    task automatic model_step();
        if (l_valid) begin
            m_wen = (l_rd_addr != 0); m_addr = l_rd_addr; m_rd = l_data;
        end else if (p_valid) begin
            m_wen = p_wen && (p_rd_addr != 0); m_addr = p_rd_addr; m_rd = p_data;
            m_inst = m_inst + 1;
        end else begin
            m_wen = 1'b0;
        end
        if (l_valid) m_pend[l_rd_addr] = 1'b0;
        if (iss_valid && iss_rd_addr != 0) m_pend[iss_rd_addr] = 1'b1;
    endtask

    task automatic idle_inputs();
        p_valid = 0; p_wen = 0; p_rd_addr = 0; p_data = 0;
        l_valid = 0; l_rd_addr = 0; l_data = 0;
        iss_valid = 0; iss_rd_addr = 0;
    endtask

    task automatic clock_step();
        model_step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 0;
        model_reset();
        @(posedge clk); @(negedge clk);
        rs1_addr = 5'd7; rs2_addr = 5'd9;
        #1;
        n_total++; if (write_en !== 1'b0) $display("FAIL reset_wen: got %b expected 0", write_en); else n_pass++;
        n_total++; if (rd_addr !== 5'd0) $display("FAIL reset_rd_addr: got %0d expected 0", rd_addr); else n_pass++;
        n_total++; if (rd !== 64'd0) $display("FAIL reset_rd: got %h expected 0", rd); else n_pass++;
        n_total++; if (instret !== 64'd0) $display("FAIL reset_instret: got %0d expected 0", instret); else n_pass++;
        n_total++; if ({rs1_busy, rs2_busy} !== 2'b00) $display("FAIL reset_busy: got %b expected 00", {rs1_busy, rs2_busy}); else n_pass++;
        n_total++; if (p_ready !== 1'b1) $display("FAIL reset_p_ready: got %b expected 1", p_ready); else n_pass++;
        rst_n = 1;
    endtask

    task automatic test_basic_write();
        p_valid = 1; p_wen = 1; p_rd_addr = 5'd5; p_data = 64'h1234;
        #1;
        n_total++; if (p_ready !== 1'b1) $display("FAIL basic_p_ready: got %b expected 1", p_ready); else n_pass++;
        clock_step();
        n_total++; if (write_en !== 1'b1) $display("FAIL basic_wen: got %b expected 1", write_en); else n_pass++;
        n_total++; if (rd_addr !== 5'd5) $display("FAIL basic_rd_addr: got %0d expected 5", rd_addr); else n_pass++;
        n_total++; if (rd !== 64'h1234) $display("FAIL basic_rd: got %h expected 1234", rd); else n_pass++;
        n_total++; if (instret !== 64'd1) $display("FAIL basic_instret: got %0d expected 1", instret); else n_pass++;
        idle_inputs();
        clock_step();
        n_total++; if (write_en !== 1'b0) $display("FAIL basic_pulse: got %b expected 0", write_en); else n_pass++;
        n_total++; if (rd !== 64'h1234 || rd_addr !== 5'd5) $display("FAIL basic_hold: got %0d/%h expected 5/1234", rd_addr, rd); else n_pass++;
    endtask

    task automatic test_x0();
        p_valid = 1; p_wen = 1; p_rd_addr = 5'd0; p_data = 64'hABCD;
        #1;
        n_total++; if (p_ready !== 1'b1) $display("FAIL x0_p_ready: got %b expected 1", p_ready); else n_pass++;
        clock_step();
        n_total++; if (write_en !== 1'b0) $display("FAIL x0_wen: got %b expected 0", write_en); else n_pass++;
        n_total++; if (instret !== m_inst) $display("FAIL x0_instret: got %0d expected %0d", instret, m_inst); else n_pass++;
        p_rd_addr = 5'd6; p_wen = 0;
        clock_step();
        n_total++; if (write_en !== 1'b0 || instret !== m_inst) $display("FAIL nowen: got %b/%0d expected 0/%0d", write_en, instret, m_inst); else n_pass++;
        idle_inputs();
    endtask

    task automatic test_hazard_priority();
        iss_valid = 1; iss_rd_addr = 5'd7;
        clock_step();
        idle_inputs();
        rs1_addr = 5'd7;
        #1;
        n_total++; if (rs1_busy !== 1'b1) $display("FAIL haz_busy_set: got %b expected 1", rs1_busy); else n_pass++;
        l_valid = 1; l_rd_addr = 5'd7; l_data = 64'hDEAD;
        p_valid = 1; p_wen = 1; p_rd_addr = 5'd3; p_data = 64'h55;
        #1;
        n_total++; if (p_ready !== 1'b0) $display("FAIL haz_p_ready: got %b expected 0", p_ready); else n_pass++;
        n_total++; if (rs1_busy !== 1'b1) $display("FAIL haz_no_bypass: got %b expected 1", rs1_busy); else n_pass++;
        clock_step();
        n_total++; if (write_en !== 1'b1 || rd !== 64'hDEAD || rd_addr !== 5'd7) $display("FAIL haz_long_write: got %b/%0d/%h expected 1/7/dead", write_en, rd_addr, rd); else n_pass++;
        n_total++; if (rs1_busy !== 1'b0) $display("FAIL haz_busy_clr: got %b expected 0", rs1_busy); else n_pass++;
        n_total++; if (instret !== m_inst) $display("FAIL haz_instret_hold: got %0d expected %0d", instret, m_inst); else n_pass++;
        l_valid = 0;
        clock_step();
        n_total++; if (write_en !== 1'b1 || rd !== 64'h55 || rd_addr !== 5'd3) $display("FAIL haz_pipe_after: got %b/%0d/%h expected 1/3/55", write_en, rd_addr, rd); else n_pass++;
        idle_inputs();
    endtask

    task automatic test_set_clr_same();
        iss_valid = 1; iss_rd_addr = 5'd9;
        l_valid = 1; l_rd_addr = 5'd9; l_data = 64'h99;
        rs2_addr = 5'd9;
        clock_step();
        idle_inputs();
        #1;
        n_total++; if (rs2_busy !== 1'b1) $display("FAIL setclr_busy: got %b expected 1", rs2_busy); else n_pass++;
        n_total++; if (write_en !== 1'b1 || rd_addr !== 5'd9 || rd !== 64'h99) $display("FAIL setclr_write: got %b/%0d/%h expected 1/9/99", write_en, rd_addr, rd); else n_pass++;
        l_valid = 1; l_rd_addr = 5'd9; l_data = 64'h100;
        clock_step();
        idle_inputs();
        #1;
        n_total++; if (rs2_busy !== 1'b0) $display("FAIL setclr_final: got %b expected 0", rs2_busy); else n_pass++;
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            logic [4:0] r;
            l_valid = ($urandom_range(0, 2) == 0);
            l_rd_addr = 5'($urandom_range(0, 31));
            l_data = {$urandom, $urandom};
            r = 5'($urandom_range(1, 31));
            iss_valid = ($urandom_range(0, 3) == 0) && !m_pend[r];
            iss_rd_addr = r;
            p_valid = $urandom_range(0, 1) == 1;
            p_wen = $urandom_range(0, 3) != 0;
            p_rd_addr = 5'($urandom_range(0, 31));
            p_data = {$urandom, $urandom};
            rs1_addr = 5'($urandom_range(0, 31));
            rs2_addr = 5'($urandom_range(0, 31));
            #1;
            n_total++; if (p_ready !== !l_valid) $display("FAIL rnd_p_ready c%0d: got %b expected %b", c, p_ready, !l_valid); else n_pass++;
            n_total++; if (rs1_busy !== (m_pend[rs1_addr] && rs1_addr != 0)) $display("FAIL rnd_rs1_busy c%0d: got %b expected %b", c, rs1_busy, m_pend[rs1_addr] && rs1_addr != 0); else n_pass++;
            n_total++; if (rs2_busy !== (m_pend[rs2_addr] && rs2_addr != 0)) $display("FAIL rnd_rs2_busy c%0d: got %b expected %b", c, rs2_busy, m_pend[rs2_addr] && rs2_addr != 0); else n_pass++;
            clock_step();
            n_total++; if (write_en !== m_wen) $display("FAIL rnd_wen c%0d: got %b expected %b", c, write_en, m_wen); else n_pass++;
            n_total++; if (rd_addr !== m_addr || rd !== m_rd) $display("FAIL rnd_data c%0d: got %0d/%h expected %0d/%h", c, rd_addr, rd, m_addr, m_rd); else n_pass++;
            n_total++; if (instret !== m_inst) $display("FAIL rnd_instret c%0d: got %0d expected %0d", c, instret, m_inst); else n_pass++;
        end
        idle_inputs();
    endtask

    task automatic test_instret_wrap();
        force dut.instret = 64'hFFFF_FFFF_FFFF_FFFF;
        #1;
        release dut.instret;
        m_inst = 64'hFFFF_FFFF_FFFF_FFFF;
        p_valid = 1; p_wen = 1; p_rd_addr = 5'd2; p_data = 64'h2;
        clock_step();
        n_total++; if (instret !== 64'd0) $display("FAIL instret_wrap: got %h expected 0", instret); else n_pass++;
        idle_inputs();
    endtask

    task automatic test_async_reset();
        iss_valid = 1; iss_rd_addr = 5'd4;
        p_valid = 1; p_wen = 1; p_rd_addr = 5'd8; p_data = 64'h88;
        rs1_addr = 5'd4;
        clock_step();
        idle_inputs();
        #1;
        n_total++; if (write_en !== 1'b1 || rs1_busy !== 1'b1) $display("FAIL arst_pre: got %b/%b expected 1/1", write_en, rs1_busy); else n_pass++;
        #1;
        rst_n = 0;
        model_reset();
        #1;
        n_total++; if (write_en !== 1'b0) $display("FAIL arst_wen: got %b expected 0", write_en); else n_pass++;
        n_total++; if (instret !== 64'd0) $display("FAIL arst_instret: got %0d expected 0", instret); else n_pass++;
        n_total++; if (rs1_busy !== 1'b0) $display("FAIL arst_pending: got %b expected 0", rs1_busy); else n_pass++;
        n_total++; if (rd !== 64'd0 || rd_addr !== 5'd0) $display("FAIL arst_rd: got %0d/%h expected 0/0", rd_addr, rd); else n_pass++;
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_basic_write();
        test_x0();
        test_hazard_priority();
        test_set_clr_same();
        test_random();
        test_instret_wrap();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
